// File: rtl/kmeans_pkg.sv
// Shared types and defaults for the k-means load/replay buffer.
// State encoding, default widths and the address-width helper.
package kmeans_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    REPLAY
  } state_t;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 4096;
  localparam int PASS_W_DEF = 4;

  // Address width for a power-of-two depth.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/kmeans_stream_buffer_if.sv
// Load and replay handshake bundle of the k-means stream buffer.
// master drives the load side and out_ready; slave is the buffer.
interface kmeans_stream_buffer_if
  import kmeans_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PASS_W = PASS_W_DEF
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [PASS_W-1:0] cfg_passes;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_done;
  logic              busy;
  logic              err;

  modport master (
    output in_valid, in_data, cfg_passes, out_ready,
    input  out_valid, out_data, out_last, out_done, busy, err
  );

  modport slave (
    input  in_valid, in_data, cfg_passes, out_ready,
    output out_valid, out_data, out_last, out_done, busy, err
  );

endinterface

// File: rtl/kmeans_buf_ram.sv
// Sample store: one write port, one synchronous read port.
// Read data holds while re is low so it can act as a skid stage.
module kmeans_buf_ram
  import kmeans_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/kmeans_stream_buffer.sv
// Load/replay buffer: capture a burst, replay it cfg_passes times.
// Pipeline is issue -> RAM read register -> output register.
module kmeans_stream_buffer
  import kmeans_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = addr_w(DEPTH),
  parameter int PASS_W = PASS_W_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  kmeans_stream_buffer_if.slave bus
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wr_cnt_q;
  logic [PASS_W-1:0] pass_tot_q;
  logic [PASS_W-1:0] pass_cnt_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              iss_end_q;
  logic              err_q;
  logic              s1_vld_q, s1_last_q, s1_done_q;
  logic              out_vld_q, out_last_q, out_done_q;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] ram_rdata;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic              re, out_ld, fire;
  logic              iss_last, iss_done;

  assign fire     = out_vld_q && bus.out_ready;
  assign out_ld   = s1_vld_q && (!out_vld_q || bus.out_ready);
  assign iss_last = ({1'b0, rd_addr_q} == wr_cnt_q - CNT_W'(1));
  assign iss_done = iss_last &&
                    (pass_cnt_q == pass_tot_q - PASS_W'(1));
  assign re       = (state_q == REPLAY) && !iss_end_q &&
                    (!s1_vld_q || out_ld);

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = LOAD;
      LOAD:    if (!bus.in_valid) state_d = REPLAY;
      REPLAY:  if (fire && out_done_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM write enable; writes past DEPTH are dropped.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    if (bus.in_valid) begin
      if (state_q == IDLE) begin
        we = 1'b1;
      end else if (state_q == LOAD && wr_cnt_q != FULL) begin
        we    = 1'b1;
        waddr = wr_cnt_q[ADDR_W-1:0];
      end
    end
  end

  // Word count, pass count latch and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt_q   <= '0;
      pass_tot_q <= '0;
      err_q      <= 1'b0;
    end else if (bus.in_valid) begin
      unique case (state_q)
        IDLE: begin
          wr_cnt_q   <= CNT_W'(1);
          pass_tot_q <= (bus.cfg_passes == '0) ?
                        PASS_W'(1) : bus.cfg_passes;
          err_q      <= 1'b0;
        end
        LOAD: begin
          if (wr_cnt_q == FULL) err_q <= 1'b1;
          else wr_cnt_q <= wr_cnt_q + CNT_W'(1);
        end
        REPLAY:  err_q <= 1'b1;
        default: err_q <= err_q;
      endcase
    end
  end

  // Read issue: address walks 0..N-1 once per pass.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_addr_q  <= '0;
      pass_cnt_q <= '0;
      iss_end_q  <= 1'b0;
    end else if (state_q == LOAD) begin
      rd_addr_q  <= '0;
      pass_cnt_q <= '0;
      iss_end_q  <= 1'b0;
    end else if (re) begin
      if (iss_last) begin
        rd_addr_q  <= '0;
        pass_cnt_q <= pass_cnt_q + PASS_W'(1);
        iss_end_q  <= iss_done;
      end else begin
        rd_addr_q <= rd_addr_q + ADDR_W'(1);
      end
    end
  end

  // RAM-output skid stage and output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_done_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_done_q <= 1'b0;
    end else begin
      if (re) begin
        s1_vld_q  <= 1'b1;
        s1_last_q <= iss_last;
        s1_done_q <= iss_done;
      end else if (out_ld) begin
        s1_vld_q <= 1'b0;
      end
      if (out_ld) begin
        out_vld_q  <= 1'b1;
        out_data_q <= ram_rdata;
        out_last_q <= s1_last_q;
        out_done_q <= s1_done_q;
      end else if (fire) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  kmeans_buf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (bus.in_data),
    .re    (re),
    .raddr (rd_addr_q),
    .rdata (ram_rdata)
  );

  assign bus.out_valid = out_vld_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_vld_q && out_last_q;
  assign bus.out_done  = out_vld_q && out_done_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_kmeans_stream_buffer.sv
// Scoreboard bench for kmeans_stream_buffer with a queue-based model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_kmeans_stream_buffer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int PASS_W = 4;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              last;
    logic              done;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   ready_mode;
  exp_t exp_q[$];

  kmeans_stream_buffer_if #(.DATA_W(DATA_W), .PASS_W(PASS_W)) bus ();

  kmeans_stream_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PASS_W (PASS_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // out_ready driver: 0 always on, 1 pattern 1,0,0,1, 2 random.
  initial begin
    int k;
    k = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       bus.out_ready = (k % 4 == 0) || (k % 4 == 3);
        2:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b1;
      endcase
      k++;
    end
  end

  // Monitor: pops on every transfer, checks hold during stalls.
  initial begin
    exp_t e;
    logic stall;
    logic [DATA_W-1:0] hd;
    logic hl, hn;
    stall = 1'b0;
    hd = '0;
    hl = 1'b0;
    hn = 1'b0;
    forever begin
      @(negedge clk);
      if (stall) begin
        checks++;
        if (!bus.out_valid || bus.out_data != hd ||
            bus.out_last != hl || bus.out_done != hn) begin
          errors++;
          $display("FAIL hold: got v=%b d=%h l=%b n=%b expected v=1 d=%h l=%b n=%b",
                   bus.out_valid, bus.out_data, bus.out_last,
                   bus.out_done, hd, hl, hn);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra: got d=%h expected no word", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_data != e.d || bus.out_last != e.last ||
              bus.out_done != e.done) begin
            errors++;
            $display("FAIL word: got d=%h l=%b n=%b expected d=%h l=%b n=%b",
                     bus.out_data, bus.out_last, bus.out_done,
                     e.d, e.last, e.done);
          end
        end
      end
      stall = bus.out_valid && !bus.out_ready;
      hd = bus.out_data;
      hl = bus.out_last;
      hn = bus.out_done;
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Drive one contiguous load; the model records the replay it implies.
  task automatic load(input logic [DATA_W-1:0] w[$],
                      input logic [PASS_W-1:0] p);
    logic [DATA_W-1:0] m[$];
    int np;
    exp_t e;
    for (int i = 0; i < w.size(); i++) begin
      bus.in_valid   = 1'b1;
      bus.in_data    = w[i];
      bus.cfg_passes = (i == 0) ? p : PASS_W'($urandom);
      if (m.size() < DEPTH) m.push_back(w[i]);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    np = (p == 0) ? 1 : int'(p);
    for (int q = 0; q < np; q++) begin
      for (int i = 0; i < m.size(); i++) begin
        e.d    = m[i];
        e.last = (i == m.size() - 1);
        e.done = (i == m.size() - 1) && (q == np - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000 || bus.out_valid) begin
      errors++;
      $display("FAIL %s drain: left=%0d busy=%b valid=%b expected 0 0 0",
               name, exp_q.size(), bus.busy, bus.out_valid);
    end
  endtask

  initial begin
    logic [DATA_W-1:0] w[$];
    logic [6:0] vpat;
    checks = 0;
    errors = 0;
    ready_mode = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.cfg_passes = '0;
    repeat (3) @(negedge clk);
    check("reset", {bus.out_valid, bus.out_data, bus.out_last,
                    bus.out_done, bus.busy, bus.err}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic replay with first-valid timing.
    w = '{16'd1024, 16'd512};
    load(w, 4'd1);
    check("busy_load", bus.busy, 1);
    vpat = '0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      vpat[k] = bus.out_valid;
    end
    check("valid_window", vpat, 7'b0001100);
    wait_done("basic");

    // Multi-pass, zero-pass, then backpressure.
    w = '{16'd1, 16'd2, 16'd3};
    load(w, 4'd3);
    wait_done("multi");
    load(w, 4'd0);
    wait_done("zero");
    ready_mode = 1;
    load(w, 4'd3);
    wait_done("bp");
    ready_mode = 0;

    // Overflow: 10 words into DEPTH=8.
    w.delete();
    for (int i = 0; i < 10; i++) w.push_back(DATA_W'(i));
    load(w, 4'd1);
    check("err_ovf", bus.err, 1);
    wait_done("ovf");
    check("err_sticky", bus.err, 1);
    w = '{16'h0055};
    load(w, 4'd2);
    check("err_clear", bus.err, 0);
    wait_done("after_ovf");

    // Mid-replay in_valid pulse, then reset mid-stream.
    w = '{16'd1, 16'd2, 16'd3};
    load(w, 4'd5);
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = 16'hdead;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("err_replay", bus.err, 1);
    repeat (2) @(negedge clk);
    check("busy_replay", bus.busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    check("mid_reset", {bus.out_valid, bus.out_data, bus.out_last,
                        bus.out_done, bus.busy, bus.err}, 32'h0);
    w = '{16'd7, 16'd8};
    load(w, 4'd2);
    wait_done("post_reset");

    // Randomized loads, pass counts and backpressure.
    for (int it = 0; it < 20; it++) begin
      int len;
      ready_mode = int'($urandom_range(0, 2));
      len = int'($urandom_range(1, 11));
      w.delete();
      for (int i = 0; i < len; i++) w.push_back(DATA_W'($urandom));
      load(w, PASS_W'($urandom_range(0, 4)));
      wait_done("rand");
      check("rand_err", bus.err, (len > DEPTH) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kmeans_stream_buffer.md
# kmeans_stream_buffer

Parametrised load/replay buffer for the k-means datapath. Captures a burst of samples on `in_valid`/`in_data`, stores up to `DEPTH` words in on-chip RAM, then streams the whole set back `cfg_passes` times, once per k-means iteration. Replay uses a valid/ready handshake with backpressure. This block supersedes the fixed two-word memory path checked by the MEM test bench.

## Interface
- `DATA_W`, 16: sample word width.
- `DEPTH`, 4096: maximum stored words. Must be a power of two, at least 2.
- `ADDR_W`, $clog2(DEPTH): RAM address width.
- `PASS_W`, 4: width of the pass count.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  load strobe. Words are contiguous while high.
- `in_data`  in  DATA_W  sample word.
- `cfg_passes`  in  PASS_W  replay count. Sampled on the first in_valid cycle of a load; 0 is treated as 1.
- `out_ready`  in  1  consumer accepts a word.
- `out_valid`  out  1  `out_data` is valid.
- `out_data`  out  DATA_W  replayed word.
- `out_last`  out  1  marks the last word of each pass.
- `out_done`  out  1  marks the last word of the final pass.
- `busy`  out  1  high in LOAD or REPLAY.
- `err`  out  1  sticky error flag. Set on overflow or on `in_valid` during REPLAY. Cleared by reset or by the start of the next load.

## Operation
States:
- **IDLE**
  - `in_valid`=1: write word 0, latch `cfg_passes`, clear `err`, go to LOAD.
- **LOAD**
  - Each `in_valid`=1 cycle writes the word at `wr_cnt` and increments `wr_cnt`.
  - The first `in_valid`=0 cycle ends the load: latch N=`wr_cnt` and go to REPLAY.
- **REPLAY**
  - Reads addresses 0..N-1 and repeats the sequence for the latched number of passes.
  - A word is transferred on any cycle with `out_valid`&&`out_ready`.
  - After the transfer that carries `out_done`, go to IDLE.

Counting and flags:
- Overflow: writes beyond `DEPTH` are dropped, `wr_cnt` saturates at `DEPTH`, and `err` is set. The load still ends normally; N=`DEPTH`.
- `in_valid` in REPLAY: the word is ignored and `err` is set. The word is not queued.
- Counters: the pass counter is PASS_W bits. The read address wraps from N-1 to 0 at each pass boundary.
- `out_last`/`out_done`: both are combinational against the registered read state and are valid only while `out_valid`=1.
- N=1: every word carries `out_last`.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_data`, `out_last` and `out_done` hold stable. No word is lost or duplicated.
- Reset mid-operation: the state returns to IDLE and all counters clear. RAM contents are not cleared; they are don't-care afterwards.

Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `out_done`=0, `busy`=0, `err`=0.

## Timing
- RAM read latency is 1 cycle. The output stage is a register plus a 1-entry skid, so backpressure causes no throughput loss.
- Let cycle T be the first sampled `in_valid`=0 after a load. `out_valid` first rises at T+2.
- With `out_ready` held at 1: one word per cycle, with no bubbles across pass boundaries. For P passes, the last word appears at T+1+N·P.
- `busy` is high from the cycle after the first `in_valid` until the cycle after the `out_done` transfer.
- After the final transfer: `out_valid`=0 on the next cycle and the state is IDLE. A new load may begin that same cycle.
- `out_ready` may toggle arbitrarily. `out_valid` never drops before its word has been transferred.

## Structure
- Shared package `kmeans_pkg`:
  - state enum {IDLE, LOAD, REPLAY};
  - default `DATA_W`;
  - helper constant for `ADDR_W`.
- Sub-module `kmeans_buf_ram`: a simple dual-port RAM with one write port and one synchronous-read port (1-cycle latency), parametrised by `DATA_W` and `DEPTH`. The top level holds the FSM, counters, skid register and flags.

## Test plan
- **Basic replay:** load 1024 then 512, `cfg_passes`=1, `out_ready`=1.
  - `out_valid` high for exactly 2 cycles starting at T+2.
  - Data 1024 then 512; `out_last` and `out_done` on 512; then `out_valid`=0.
- **Multi-pass:** load 1,2,3, `cfg_passes`=3.
  - 9 consecutive words 1,2,3,1,2,3,1,2,3.
  - `out_last` on each 3; `out_done` only on the final 3.
- **Zero passes:** `cfg_passes`=0 behaves identically to 1.
- **Backpressure:** same load as multi-pass, with `out_ready` toggling 1,0,0,1 repeatedly.
  - Data is stable during stalls; the sequence is exact with no loss or duplication.
- **Overflow:** build with `DEPTH`=8 and load 10 words 0..9.
  - `err`=1; replay outputs 0..7 only.
  - `err` clears on the next load.
- **Mid-replay abuse:** during REPLAY, drive `in_valid`=1 for one cycle, which must set `err` while the stream continues unchanged. Then assert `rst_n`=0 for one cycle mid-stream, and check:
  - on the next cycle, all outputs are 0 and the state is IDLE;
  - a subsequent load/replay works correctly.
